// File: rtl/rr_mux_arb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_mux_arb : registered N:1 valid/ready mux, fixed-select or RR grant |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
module rr_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [SELW-1:0] LAST_RST = SELW'(NCH - 1);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_data;
  int               rr_tgt;

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_tgt    = 0;
    if (!mode) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(i);
        end
      end
    end else begin
      // Scan farthest-first so the nearest valid channel after last wins.
      for (int k = NCH; k >= 1; k--) begin
        rr_tgt = (int'(last_q) + k) % NCH;
        for (int i = 0; i < NCH; i++) begin
          if (i == rr_tgt && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    end
    if (!rst_n) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ready
    assign in_ready[i] = load_en && grant_vld && (grant_idx == SELW'(i));
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (load_en && grant_vld) begin
      out_data_d  = grant_data;
      out_ch_d    = grant_idx;
      out_valid_d = 1'b1;
      last_d      = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised, registered N-channel multiplexer with valid/ready handshaking and two selection modes: fixed select and round-robin arbitration. It is the sequential successor of the team's gate-level 4:1 mux. It sits between several producer channels and one consumer and forwards one word per cycle through a single output register. Each forwarded word is tagged with the index of its source channel.

## Interface
- WIDTH, 8, data bits per channel
- NCH, 4, number of input channels (2..16)
- SELW, 2, width of select and channel-index fields; must satisfy 2^SELW >= NCH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  channel i has a word
- in_ready  output  NCH  channel i's word is accepted this cycle (combinational)
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SELW  channel index used in fixed mode
- out_data  output  WIDTH  registered output word
- out_ch  output  SELW  registered source channel of out_data
- out_valid  output  1  out_data/out_ch hold a word
- out_ready  input  1  consumer accepts the word

## Operation
- The output register is loadable when `!out_valid || out_ready`. This signal is `load_en`.
- Grant selection is combinational and is evaluated every cycle:
  - mode=0: grant = sel if sel < NCH and in_valid[sel]. Otherwise there is no grant. Other channels are never served.
  - mode=1: scan channels last+1, last+2, … (mod NCH). The first channel with in_valid set is granted. Otherwise there is no grant.
- in_ready[i] = load_en && grant exists && grant == i. At most one bit of in_ready is ever high.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= channel i data
  - out_ch <= i
  - out_valid <= 1
  - last <= i
- When out_valid && out_ready and no new grant exists: out_valid <= 0. out_data and out_ch keep their last value.
- `last` (SELW bits) updates on every accepted transfer, in either mode. A switch from mode 0 to mode 1 therefore resumes rotation after the most recently served channel.
- mode and sel are sampled each cycle. A change affects the next arbitration only. A word already in the output register is never altered.
- Producers must hold in_data/in_valid stable until accepted. The block does not check this.

## Timing
- Reset (asynchronous assert, synchronous release by the system) sets:
  - out_valid = 0
  - out_data = 0
  - out_ch = 0
  - last = NCH-1, so the first round-robin scan starts at channel 0
- During reset, in_ready = 0 (load_en is high but no grant is issued while rst_n = 0).
- Latency is 1 cycle: a word accepted at edge k appears on out_data with out_valid=1 after edge k.
- Throughput is 1 word per cycle while out_ready=1. Accept and drain in the same cycle is legal and produces no bubble.
- Back-pressure: out_valid=1 && out_ready=0 forces in_ready=0 on all channels, and out_* hold stable.
- Round-robin fairness: with all NCH channels continuously valid and out_ready=1, the grant order is 0,1,…,NCH-1,0,… One channel is served per cycle, and no channel waits more than NCH-1 grants.
- Wrap-around: when last = NCH-1, the scan restarts at 0. When only the last-served channel is valid, it is granted again.
- If sel >= NCH (non-power-of-2 NCH), mode 0 grants nothing and the output drains normally.
- Reset mid-transfer discards the word in the output register. No in_ready pulse occurs while rst_n = 0.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data and out_ch read 0 immediately (asynchronous), and in_ready=0. After release with all in_valid=0, out_valid stays 0.
- Fixed mode, NCH=4, WIDTH=8: sel=2, channel data 0x11/0x22/0x33/0x44, all valid, out_ready=1 -> in_ready=4'b0100 every cycle. out_data=0x33 and out_ch=2 from the cycle after the first accept.
- Round-robin, all four channels valid, out_ready=1 -> out_ch sequence 0,1,2,3,0,1. in_ready is one-hot and rotates each cycle with no bubbles.
- Round-robin, only channels 1 and 3 valid, starting from reset -> grants 1,3,1,3. With only channel 3 valid after last=3 -> channel 3 is granted again (wrap-around).
- Back-pressure: out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0 and out_data/out_ch unchanged. Raise out_ready -> the next word loads in the same edge that drains the current one.
- Mode switch: serve channel 2 in mode 0, switch to mode 1 with all valid -> the next grant is channel 3, then 0. With NCH=3 and sel=3 in mode 0 -> no grant, and out_valid falls after the drain.
